// File: rtl/onehot_pulse_decoder_pkg.sv
// Shared definitions for the one-hot pulse decoder and its companion priority
// encoder: state encoding, channel-count defaults and a clog2 helper.
package onehot_pulse_decoder_pkg;

  localparam int unsigned DEF_IDX_W = 3;
  localparam int unsigned DEF_OUT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/onehot_pulse_decoder_hold_counter.sv
// Loadable down-counter that parks at zero; shared by the PULSE and GAP phases.
module hold_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o,
  output logic             one_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);
  assign one_o  = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/onehot_pulse_decoder.sv
// Sequential 3-to-8 decoder: accepts an encoded channel over valid/ready and
// drives the matching one-hot line for PULSE_CYCLES, followed by an idle gap.
module onehot_pulse_decoder
  import onehot_pulse_decoder_pkg::*;
#(
  parameter int unsigned IDX_W        = DEF_IDX_W,
  parameter int unsigned OUT_W        = DEF_OUT_W,
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             abort,
  output logic [OUT_W-1:0] y,
  output logic             y_active,
  output logic             done,
  output logic             err
);

  localparam int unsigned MAX_PG = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W  = clog2((MAX_PG > 2) ? MAX_PG : 2);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);

  state_e           state_q, state_d;
  logic [OUT_W-1:0] y_q, y_d;
  logic             act_q, act_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             cnt_clr, cnt_load, cnt_zero, cnt_one;
  logic [CNT_W-1:0] cnt_val;

  assign in_ready = (state_q == ST_IDLE) & ~abort;

  hold_counter #(.CNT_W(CNT_W)) u_hold_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero),
    .one_o      (cnt_one)
  );

  // done is registered, so it is raised on the edge that makes the counter reach 0 in PULSE
  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    act_d    = act_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          if (32'(in_idx) < OUT_W) begin
            state_d  = ST_PULSE;
            y_d      = OUT_W'(1) << in_idx;
            act_d    = 1'b1;
            cnt_load = 1'b1;
            cnt_val  = PULSE_LD;
            done_d   = (PULSE_CYCLES == 1);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_PULSE: begin
        if (abort) begin
          state_d = ST_IDLE;
          y_d     = '0;
          act_d   = 1'b0;
          cnt_clr = 1'b1;
        end else if (cnt_zero) begin
          y_d   = '0;
          act_d = 1'b0;
          if (GAP_CYCLES > 0) begin
            state_d  = ST_GAP;
            cnt_load = 1'b1;
            cnt_val  = GAP_LD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          done_d = cnt_one;
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end else if (cnt_zero) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        y_d     = '0;
        act_d   = 1'b0;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      act_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      act_q   <= act_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign y        = y_q;
  assign y_active = act_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
